// File: rtl/cmd_decoder_mc.sv
// Multi-channel UART command decoder.
// Parses framed commands from the UART receiver, range-checks the channel and
// amount fields, aborts stalled frames on timeout and posts accepted frames on
// a registered commit bus with a per-channel control bank.
// Optional build macro: CMD_DEC_CHECKSUM_EN (adds a trailing XOR checksum byte).
module cmd_decoder_mc #(
  parameter int DATA_BIT    = 32,
  parameter int CH_NUM      = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [7:0]            data_i,
  input  logic                  rx_done_tick_i,
  output logic [7:0]            cmd_o,
  output logic [7:0]            ch_o,
  output logic [7:0]            amount_o,
  output logic [DATA_BIT-1:0]   pattern_o,
  output logic [7:0]            arg0_o,
  output logic [7:0]            arg1_o,
  output logic [CH_NUM-1:0]     enable_o,
  output logic [CH_NUM-1:0]     idle_o,
  output logic [2*CH_NUM-1:0]   mode_o,
  output logic                  done_tick_o,
  output logic                  err_tick_o,
  output logic [2:0]            err_code_o
);

  localparam int NB = DATA_BIT / 8;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = $clog2(NB + 1);

  // Command codes shared with the host-side tooling.
  localparam logic [7:0] CMD_PERIOD = 8'h01;
  localparam logic [7:0] CMD_FREQ   = 8'h02;
  localparam logic [7:0] CMD_DATA   = 8'h03;
  localparam logic [7:0] CMD_CTRL   = 8'h04;
  localparam logic [7:0] CMD_REPEAT = 8'h05;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHAN = 3'd1;
  localparam logic [2:0] S_AMT  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  logic [2:0]          state;
  logic [7:0]          cmd_q;
  logic [CW-1:0]       cnt;
  logic [TW-1:0]       timer;
  logic [7:0]          ch_q, amt_q, a0_q, a1_q, csum_q;
  logic [DATA_BIT-1:0] pat_q;
  logic [DATA_BIT-1:0] pat_n;
  logic [7:0]          a0_n, a1_n;
  logic                pay_last;
  logic                commit;

  // Pattern bytes enter at the top so the first byte ends up in bits [7:0].
  function automatic logic [DATA_BIT-1:0] shift_in(input logic [DATA_BIT-1:0] p,
                                                   input logic [7:0] b);
    logic [DATA_BIT-1:0] wide;
    wide = DATA_BIT'(b);
    return (p >> 8) | (wide << (DATA_BIT - 8));
  endfunction

  // Number of bytes collected in S_PAY for a given command.
  function automatic int pay_len(input logic [7:0] c);
    case (c)
      CMD_PERIOD:         return 2;
      CMD_FREQ, CMD_DATA: return NB;
      default:            return 1;
    endcase
  endfunction

  // Shadow registers as they look including the byte arriving this cycle;
  // commit reads these so the last payload byte needs no extra cycle.
  always_comb begin
    pat_n    = pat_q;
    a0_n     = a0_q;
    a1_n     = a1_q;
    pay_last = 1'b0;
    if (state == S_PAY && rx_done_tick_i) begin
      pat_n = shift_in(pat_q, data_i);
      if (cnt == CW'(0)) a0_n = data_i;
      if (cnt == CW'(1)) a1_n = data_i;
      pay_last = (32'(cnt) == pay_len(cmd_q) - 1);
    end
  end

`ifdef CMD_DEC_CHECKSUM_EN
  assign commit = (state == S_CSUM) && rx_done_tick_i && (data_i == csum_q);
`else
  assign commit = pay_last;
`endif

  // Frame shadow data: channel, amount, payload bytes and running checksum.
  always_ff @(posedge clk_i) begin
    pat_q <= pat_n;
    a0_q  <= a0_n;
    a1_q  <= a1_n;
    if (rx_done_tick_i) begin
      csum_q <= (state == S_IDLE) ? data_i : (csum_q ^ data_i);
      if (state == S_CHAN) ch_q  <= data_i;
      if (state == S_AMT)  amt_q <= data_i;
    end
  end

  // Frame FSM, inter-byte timer, error reporting and commit bus / banks.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cmd_q       <= 8'h00;
      cnt         <= '0;
      timer       <= '0;
      cmd_o       <= 8'h00;
      ch_o        <= 8'h00;
      amount_o    <= 8'h00;
      pattern_o   <= '0;
      arg0_o      <= 8'h00;
      arg1_o      <= 8'h00;
      enable_o    <= '0;
      idle_o      <= '0;
      mode_o      <= '0;
      done_tick_o <= 1'b0;
      err_tick_o  <= 1'b0;
      err_code_o  <= 3'd0;
    end else begin
      done_tick_o <= 1'b0;
      err_tick_o  <= 1'b0;
      if (rx_done_tick_i || state == S_IDLE) timer <= '0;
      else                                   timer <= timer + TW'(1);

      if (rx_done_tick_i) begin
        case (state)
          S_IDLE: begin
            cnt   <= '0;
            cmd_q <= data_i;
            case (data_i)
              CMD_DATA, CMD_CTRL, CMD_REPEAT: state <= S_CHAN;
              CMD_FREQ:                       state <= S_AMT;
              CMD_PERIOD:                     state <= S_PAY;
              default: begin
                err_tick_o <= 1'b1;
                err_code_o <= 3'd1;
              end
            endcase
          end
          S_CHAN: begin
            if (32'(data_i) >= CH_NUM) begin
              err_tick_o <= 1'b1;
              err_code_o <= 3'd2;
              state      <= S_IDLE;
            end else begin
              state <= (cmd_q == CMD_DATA) ? S_AMT : S_PAY;
            end
          end
          S_AMT: begin
            if (data_i == 8'h00 || 32'(data_i) > DATA_BIT) begin
              err_tick_o <= 1'b1;
              err_code_o <= 3'd3;
              state      <= S_IDLE;
            end else begin
              state <= S_PAY;
            end
          end
          S_PAY: begin
            cnt <= cnt + CW'(1);
`ifdef CMD_DEC_CHECKSUM_EN
            if (pay_last) state <= S_CSUM;
`else
            if (pay_last) state <= S_IDLE;
`endif
          end
          S_CSUM: begin
            state <= S_IDLE;
            if (!commit) begin
              err_tick_o <= 1'b1;
              err_code_o <= 3'd5;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE && timer == TW'(TIMEOUT_CYC - 1)) begin
        err_tick_o <= 1'b1;
        err_code_o <= 3'd4;
        state      <= S_IDLE;
        timer      <= '0;
      end

      if (commit) begin
        done_tick_o <= 1'b1;
        cmd_o       <= cmd_q;
        case (cmd_q)
          CMD_PERIOD: begin
            ch_o   <= 8'h00;
            arg0_o <= a0_n;
            arg1_o <= a1_n;
          end
          CMD_FREQ: begin
            ch_o      <= 8'h00;
            amount_o  <= amt_q;
            pattern_o <= pat_n;
          end
          CMD_DATA: begin
            ch_o      <= ch_q;
            amount_o  <= amt_q;
            pattern_o <= pat_n;
          end
          CMD_CTRL: begin
            ch_o <= ch_q;
            for (int k = 0; k < CH_NUM; k++) begin
              if (32'(ch_q) == k) begin
                enable_o[k]     <= a0_n[0];
                mode_o[2*k +: 2] <= a0_n[2:1];
                idle_o[k]       <= a0_n[3];
              end
            end
          end
          CMD_REPEAT: begin
            ch_o   <= ch_q;
            arg0_o <= a0_n;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_decoder_mc.sv
// Directed testbench for cmd_decoder_mc (CH_NUM=8, DATA_BIT=32, short timeout).
module tb_cmd_decoder_mc;

  localparam int DATA_BIT    = 32;
  localparam int CH_NUM      = 8;
  localparam int TIMEOUT_CYC = 20;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [7:0]          data_i;
  logic                rx_done_tick_i;
  logic [7:0]          cmd_o, ch_o, amount_o, arg0_o, arg1_o;
  logic [DATA_BIT-1:0] pattern_o;
  logic [CH_NUM-1:0]   enable_o, idle_o;
  logic [2*CH_NUM-1:0] mode_o;
  logic                done_tick_o, err_tick_o;
  logic [2:0]          err_code_o;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [7:0] cs;

  cmd_decoder_mc #(
    .DATA_BIT(DATA_BIT), .CH_NUM(CH_NUM), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .rx_done_tick_i(rx_done_tick_i),
    .cmd_o(cmd_o), .ch_o(ch_o), .amount_o(amount_o), .pattern_o(pattern_o),
    .arg0_o(arg0_o), .arg1_o(arg1_o), .enable_o(enable_o), .idle_o(idle_o),
    .mode_o(mode_o), .done_tick_o(done_tick_o), .err_tick_o(err_tick_o),
    .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  // Tally strobes away from the active edge.
  always @(negedge clk_i) begin
    if (done_tick_o) done_cnt++;
    if (err_tick_o)  err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte strobe; consecutive calls give back-to-back strobes.
  task automatic tx(input logic [7:0] b);
    data_i         = b;
    rx_done_tick_i = 1'b1;
    cs             = cs ^ b;
    @(posedge clk_i); #1;
    rx_done_tick_i = 1'b0;
  endtask

  task automatic begin_frame();
    cs = 8'h00;
  endtask

  task automatic end_frame();
`ifdef CMD_DEC_CHECKSUM_EN
    tx(cs);
`endif
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, elapsed;
    bit seen;
    rst_ni = 1'b0; data_i = 8'h00; rx_done_tick_i = 1'b0; cs = 8'h00;
    idle_cycles(3);
    check("reset_outputs", {cmd_o, ch_o, amount_o, arg0_o, arg1_o, pattern_o[23:0]}, 64'h0);
    check("reset_banks", {enable_o, idle_o, mode_o, done_tick_o, err_tick_o, err_code_o}, 64'h0);
    rst_ni = 1'b1;
    idle_cycles(2);

    // PERIOD slow=0x14 fast=0x05
    begin_frame(); tx(8'h01); tx(8'h14); tx(8'h05); end_frame();
    check("period_done", done_tick_o, 1'b1);
    check("period_args", {cmd_o, ch_o, arg0_o, arg1_o}, {8'h01, 8'h00, 8'h14, 8'h05});
    idle_cycles(2);

    // DATA ch5 amt4 EE DD CC BB
    d0 = done_cnt;
    begin_frame(); tx(8'h03); tx(8'h05); tx(8'h04);
    tx(8'hEE); tx(8'hDD); tx(8'hCC); tx(8'hBB); end_frame();
    check("data_done", done_tick_o, 1'b1);
    check("data_bus", {cmd_o, ch_o, amount_o, pattern_o}, {8'h03, 8'h05, 8'h04, 32'hBBCCDDEE});
    idle_cycles(2);
    check("data_one_tick", done_cnt - d0, 1);

    // CTRL ch5 0x0B, then ch2 0x04
    begin_frame(); tx(8'h04); tx(8'h05); tx(8'h0B); end_frame();
    check("ctrl5_banks", {enable_o, idle_o, mode_o}, {8'h20, 8'h20, 16'h0400});
    idle_cycles(1);
    begin_frame(); tx(8'h04); tx(8'h02); tx(8'h04); end_frame();
    check("ctrl2_banks", {enable_o, idle_o, mode_o}, {8'h20, 8'h20, 16'h0420});
    idle_cycles(1);

    // CTRL ch8 -> bad channel
    d0 = done_cnt;
    tx(8'h04); tx(8'h08);
    check("badch_err", {err_tick_o, err_code_o}, {1'b1, 3'd2});
    idle_cycles(2);
    check("badch_banks", {enable_o, idle_o, mode_o, done_cnt - d0}, {8'h20, 8'h20, 16'h0420, 32'd0});

    // REPEAT ch5 count 3 accepted afterwards
    begin_frame(); tx(8'h05); tx(8'h05); tx(8'h03); end_frame();
    check("repeat_bus", {done_tick_o, cmd_o, ch_o, arg0_o}, {1'b1, 8'h05, 8'h05, 8'h03});
    idle_cycles(1);

    // DATA amount 0x21 -> bad amount; 0xFF -> unknown cmd
    d0 = done_cnt;
    tx(8'h03); tx(8'h01); tx(8'h21);
    check("badamt_err", {err_tick_o, err_code_o}, {1'b1, 3'd3});
    idle_cycles(1);
    check("err_code_holds", {err_tick_o, err_code_o}, {1'b0, 3'd3});
    tx(8'hFF);
    check("badcmd_err", {err_tick_o, err_code_o}, {1'b1, 3'd1});
    idle_cycles(2);
    check("err_no_done", done_cnt - d0, 0);

    // FREQ amt8 11 22 33 44 with no gaps
    begin_frame(); tx(8'h02); tx(8'h08); tx(8'h11); tx(8'h22); tx(8'h33); tx(8'h44); end_frame();
    check("freq_bus", {cmd_o, ch_o, amount_o, pattern_o}, {8'h02, 8'h00, 8'h08, 32'h44332211});
    idle_cycles(1);

    // Stall after two bytes -> timeout
    tx(8'h03); tx(8'h01);
    seen = 1'b0; elapsed = 0;
    for (int i = 1; i <= 2 * TIMEOUT_CYC && !seen; i++) begin
      @(posedge clk_i); #1;
      if (err_tick_o) begin seen = 1'b1; elapsed = i; end
    end
    check("timeout_seen", {seen, err_code_o}, {1'b1, 3'd4});
    check("timeout_latency", elapsed, TIMEOUT_CYC);
    begin_frame(); tx(8'h01); tx(8'h22); tx(8'h33); end_frame();
    check("after_timeout", {done_tick_o, arg0_o, arg1_o}, {1'b1, 8'h22, 8'h33});
    idle_cycles(1);

`ifdef CMD_DEC_CHECKSUM_EN
    begin_frame(); tx(8'h05); tx(8'h05); tx(8'h07); end_frame();
    check("csum_ok", {done_tick_o, arg0_o}, {1'b1, 8'h07});
    idle_cycles(1);
    tx(8'h05); tx(8'h05); tx(8'h03); tx(8'h03 ^ 8'hFF);
    check("csum_bad", {err_tick_o, err_code_o, done_tick_o, arg0_o}, {1'b1, 3'd5, 1'b0, 8'h07});
    idle_cycles(1);
`endif

    // Reset mid-frame: everything cleared, no error strobe
    e0 = err_cnt;
    tx(8'h03); tx(8'h05);
    rst_ni = 1'b0;
    idle_cycles(1);
    check("midrst_outputs", {cmd_o, ch_o, amount_o, arg0_o, arg1_o, pattern_o[23:0]}, 64'h0);
    check("midrst_banks", {enable_o, idle_o, mode_o, done_tick_o, err_tick_o, err_code_o}, 64'h0);
    rst_ni = 1'b1;
    idle_cycles(2);
    check("midrst_no_err", err_cnt - e0, 0);
    begin_frame(); tx(8'h01); tx(8'h44); tx(8'h55); end_frame();
    check("after_reset", {done_tick_o, cmd_o, arg0_o, arg1_o}, {1'b1, 8'h01, 8'h44, 8'h55});
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
